// File: rtl/chinx_pkg.sv
// Shared constants, branch-source codes and fetch-state encoding for the chinx pipeline.
package chinx_pkg;

    localparam int unsigned ADDR_WIDTH       = 8;
    localparam int unsigned INSTR_WIDTH      = 32;
    localparam int unsigned BRANCH_SRC_WIDTH = 3;

    localparam logic LEV_H = 1'b1;
    localparam logic LEV_L = 1'b0;

    localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0000;

    localparam logic [BRANCH_SRC_WIDTH-1:0] BRANCH_SRC_NONE = 3'd0;
    localparam logic [BRANCH_SRC_WIDTH-1:0] BRANCH_SRC_BEQ  = 3'd1;
    localparam logic [BRANCH_SRC_WIDTH-1:0] BRANCH_SRC_BNE  = 3'd2;
    localparam logic [BRANCH_SRC_WIDTH-1:0] BRANCH_SRC_JAL  = 3'd3;
    localparam logic [BRANCH_SRC_WIDTH-1:0] BRANCH_SRC_JALR = 3'd4;

    typedef enum logic {
        S_RUN = 1'b0,
        S_IRQ = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/chinx_irqsync.sv
// Interrupt front end: per-line 2-flop synchroniser, rising-edge capture into pending bits,
// masking and lowest-index priority selection.
module chinx_irqsync
    import chinx_pkg::*;
#(
    parameter int unsigned IRQ_NUM = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IRQ_NUM-1:0]         irq_i,
    input  logic [IRQ_NUM-1:0]         mask_i,
    input  logic                       clr_i,
    input  logic [$clog2(IRQ_NUM)-1:0] clr_id_i,
    output logic                       pending_any_o,
    output logic [$clog2(IRQ_NUM)-1:0] id_o
);

    localparam int unsigned IDW = $clog2(IRQ_NUM);

    logic [IRQ_NUM-1:0] sync1_q, sync1_d;
    logic [IRQ_NUM-1:0] sync2_q, sync2_d;
    logic [IRQ_NUM-1:0] prev_q, prev_d;
    logic [IRQ_NUM-1:0] pend_q, pend_d;
    logic [IRQ_NUM-1:0] clr_vec;
    logic [IRQ_NUM-1:0] req;

    // A new edge wins over an acknowledge of the same bit: it is a fresh request.
    always_comb begin
        sync1_d = irq_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        clr_vec = '0;
        for (int i = 0; i < int'(IRQ_NUM); i++) begin
            clr_vec[i] = clr_i && (clr_id_i == IDW'(i));
        end
        pend_d = (pend_q & ~clr_vec) | (sync2_q & ~prev_q);
    end

    always_comb begin
        req           = pend_q & ~mask_i;
        pending_any_o = |req;
        id_o          = '0;
        for (int i = int'(IRQ_NUM) - 1; i >= 0; i--) begin
            if (req[i]) begin
                id_o = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: rtl/chinx_stage1.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory,
// handles stage-2 redirects and raises interrupt requests at instruction boundaries.
module chinx_stage1
    import chinx_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 8'h00,
    parameter int unsigned           IRQ_NUM  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        hold_i,
    input  logic [BRANCH_SRC_WIDTH-1:0] bsrc_i,
    input  logic [ADDR_WIDTH-1:0]       bpc_i,
    input  logic                        irep_i,
    input  logic [IRQ_NUM-1:0]          irq_i,
    input  logic [IRQ_NUM-1:0]          irq_mask_i,
    output logic [ADDR_WIDTH-1:0]       imem_addr_o,
    output logic                        imem_en_o,
    input  logic [INSTR_WIDTH-1:0]      imem_rdata_i,
    output logic [ADDR_WIDTH-1:0]       pc_o,
    output logic [INSTR_WIDTH-1:0]      instr_o,
    output logic                        ireq_o,
    output logic [$clog2(IRQ_NUM)-1:0]  irq_id_o
);

    localparam int unsigned IDW = $clog2(IRQ_NUM);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
    logic                  valid_q, valid_d;
    logic [IDW-1:0]        id_q, id_d;

    logic [ADDR_WIDTH-1:0] fall_pc;
    logic                  redirect;
    logic                  irq_clr;
    logic                  pending_any;
    logic [IDW-1:0]        pend_id;

    chinx_irqsync #(
        .IRQ_NUM (IRQ_NUM)
    ) u_irqsync (
        .clk           (clk),
        .rst           (rst),
        .irq_i         (irq_i),
        .mask_i        (irq_mask_i),
        .clr_i         (irq_clr),
        .clr_id_i      (id_q),
        .pending_any_o (pending_any),
        .id_o          (pend_id)
    );

    // A branch whose target equals the fall-through PC needs no refetch.
    assign fall_pc  = ipc_q + PC_STEP;
    assign redirect = (state_q == S_RUN) && (bsrc_i != BRANCH_SRC_NONE) && (bpc_i != fall_pc);

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        id_d    = id_q;
        irq_clr = 1'b0;
        case (state_q)
            S_RUN: begin
                if (!hold_i) begin
                    if (redirect) begin
                        fpc_d   = bpc_i;
                        valid_d = 1'b0;
                    end else if (valid_q && pending_any) begin
                        // Slot instruction is left un-executed and replayed on return.
                        state_d = S_IRQ;
                        id_d    = pend_id;
                    end else begin
                        ipc_d   = fpc_q;
                        fpc_d   = fpc_q + PC_STEP;
                        valid_d = 1'b1;
                    end
                end
            end
            S_IRQ: begin
                if (irep_i) begin
                    irq_clr = 1'b1;
                    state_d = S_RUN;
                    fpc_d   = bpc_i;
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            fpc_q   <= RESET_PC;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        imem_addr_o = fpc_q;
        imem_en_o   = rst || ((state_q == S_RUN) && !hold_i);
        ireq_o      = (state_q == S_IRQ);
        irq_id_o    = id_q;
        pc_o        = (state_q == S_IRQ) ? ipc_q : fall_pc;
        instr_o     = ((state_q == S_RUN) && valid_q) ? imem_rdata_i : INSTR_NOP;
    end

endmodule

// File: tb/tb_chinx_stage1.sv
// Directed bench for chinx_stage1: fetch sequence, redirects, hold, interrupts, wrap and reset.
module tb_chinx_stage1;
    import chinx_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        hold_i;
    logic [BRANCH_SRC_WIDTH-1:0] bsrc_i;
    logic [ADDR_WIDTH-1:0]       bpc_i;
    logic                        irep_i;
    logic [3:0]                  irq_i;
    logic [3:0]                  irq_mask_i;
    logic [ADDR_WIDTH-1:0]       imem_addr_o;
    logic                        imem_en_o;
    logic [INSTR_WIDTH-1:0]      imem_rdata_i = '0;
    logic [ADDR_WIDTH-1:0]       pc_o;
    logic [INSTR_WIDTH-1:0]      instr_o;
    logic                        ireq_o;
    logic [1:0]                  irq_id_o;

    logic [31:0] mem [64];
    int total = 0;
    int bad   = 0;

    chinx_stage1 #(
        .RESET_PC (8'h00),
        .IRQ_NUM  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hold_i       (hold_i),
        .bsrc_i       (bsrc_i),
        .bpc_i        (bpc_i),
        .irep_i       (irep_i),
        .irq_i        (irq_i),
        .irq_mask_i   (irq_mask_i),
        .imem_addr_o  (imem_addr_o),
        .imem_en_o    (imem_en_o),
        .imem_rdata_i (imem_rdata_i),
        .pc_o         (pc_o),
        .instr_o      (instr_o),
        .ireq_o       (ireq_o),
        .irq_id_o     (irq_id_o)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory, output holds while disabled.
    always @(posedge clk) begin
        if (imem_en_o) imem_rdata_i <= mem[imem_addr_o[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_slot(input string tag, input logic [31:0] ins, input logic [7:0] pc);
        chk({tag, ".instr"}, instr_o, ins);
        chk({tag, ".pc"}, 32'(pc_o), 32'(pc));
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + 32'(k);
        rst = 1'b1; hold_i = 1'b0; bsrc_i = BRANCH_SRC_NONE; bpc_i = '0;
        irep_i = 1'b0; irq_i = '0; irq_mask_i = '0;
        step(2);
        chk("rst.addr", 32'(imem_addr_o), 32'h00);
        chk("rst.en", 32'(imem_en_o), 32'd1);
        chk_slot("rst", 32'h0, 8'h04);
        chk("rst.ireq", 32'(ireq_o), 32'd0);
        chk("rst.id", 32'(irq_id_o), 32'd0);

        // Fetch start-up after reset release
        rst = 1'b0;
        chk_slot("c1", 32'h0, 8'h04);
        step(1); chk_slot("c2", 32'h1000_0000, 8'h04);
        step(1); chk_slot("c3", 32'h1000_0001, 8'h08);
        step(1); chk_slot("c4", 32'h1000_0002, 8'h0C);
        step(2); chk_slot("s10", 32'h1000_0004, 8'h14);

        // Taken branch to 0x40: one bubble then target
        bsrc_i = BRANCH_SRC_BEQ; bpc_i = 8'h40;
        step(1); bsrc_i = BRANCH_SRC_NONE;
        chk_slot("br.bubble", 32'h0, 8'h14);
        step(1); chk_slot("br.tgt", 32'h1000_0010, 8'h44);

        // Branch to fall-through PC: no bubble
        bsrc_i = BRANCH_SRC_BNE; bpc_i = 8'h44;
        step(1); bsrc_i = BRANCH_SRC_NONE;
        chk_slot("ft", 32'h1000_0011, 8'h48);

        // Redirect to 0x20, then hold for three cycles
        bsrc_i = BRANCH_SRC_JAL; bpc_i = 8'h20;
        step(1); bsrc_i = BRANCH_SRC_NONE;
        chk_slot("j20.bubble", 32'h0, 8'h48);
        step(1); chk_slot("j20.tgt", 32'h1000_0008, 8'h24);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_slot("hold", 32'h1000_0008, 8'h24);
            chk("hold.addr", 32'(imem_addr_o), 32'h24);
            chk("hold.en", 32'(imem_en_o), 32'd0);
        end
        hold_i = 1'b0;
        step(1); chk_slot("resume", 32'h1000_0009, 8'h28);

        // Simultaneous edges on lines 2 and 1: line 1 wins
        irq_i = 4'b0110;
        step(3); chk_slot("pre.irq", 32'h1000_000C, 8'h34);
        chk("pre.ireq", 32'(ireq_o), 32'd0);
        step(1);
        chk("irq1.ireq", 32'(ireq_o), 32'd1);
        chk("irq1.id", 32'(irq_id_o), 32'd1);
        chk_slot("irq1", 32'h0, 8'h30);
        chk("irq1.en", 32'(imem_en_o), 32'd0);
        hold_i = 1'b1;
        step(1); hold_i = 1'b0;
        step(1); chk("irq1.wait", 32'(ireq_o), 32'd1);
        irep_i = 1'b1; bpc_i = 8'hF0;
        step(1); irep_i = 1'b0;
        chk("ack1.ireq", 32'(ireq_o), 32'd0);
        chk("ack1.addr", 32'(imem_addr_o), 32'hF0);
        chk_slot("ack1", 32'h0, 8'h34);
        step(1); chk_slot("vec1", 32'h1000_003C, 8'hF4);
        chk("vec1.ireq", 32'(ireq_o), 32'd0);

        // Line 2 still pending: requested at the next boundary
        step(1);
        chk("irq2.ireq", 32'(ireq_o), 32'd1);
        chk("irq2.id", 32'(irq_id_o), 32'd2);
        chk("irq2.pc", 32'(pc_o), 32'hF0);

        // Return into 0xFC exercises address wrap
        irep_i = 1'b1; bpc_i = 8'hFC;
        step(1); irep_i = 1'b0;
        chk("ack2.ireq", 32'(ireq_o), 32'd0);
        chk("ack2.addr", 32'(imem_addr_o), 32'hFC);
        step(1); chk_slot("wrap", 32'h1000_003F, 8'h00);
        chk("wrap.addr", 32'(imem_addr_o), 32'h00);
        step(1); chk_slot("wrap2", 32'h1000_0000, 8'h04);

        // Masked edge stays pending until unmasked
        irq_mask_i = 4'b0001; irq_i = 4'b0111;
        step(4);
        chk("mask.ireq", 32'(ireq_o), 32'd0);
        chk_slot("mask", 32'h1000_0004, 8'h14);
        irq_mask_i = 4'b0000;
        step(1);
        chk("unmask.ireq", 32'(ireq_o), 32'd1);
        chk("unmask.id", 32'(irq_id_o), 32'd0);
        chk("unmask.pc", 32'(pc_o), 32'h10);

        // Asynchronous reset while requesting
        rst = 1'b1;
        #1;
        chk("arst.ireq", 32'(ireq_o), 32'd0);
        chk("arst.id", 32'(irq_id_o), 32'd0);
        chk("arst.addr", 32'(imem_addr_o), 32'h00);
        chk_slot("arst", 32'h0, 8'h04);
        irq_i = '0;
        step(2);
        rst = 1'b0;
        step(1); chk_slot("post.c2", 32'h1000_0000, 8'h04);
        step(5);
        chk("post.ireq", 32'(ireq_o), 32'd0);
        chk_slot("post", 32'h1000_0005, 8'h18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
